guess_player_port: RTL and testbench
====================================

# guess_player_port

Player-side front end for the guessing-game FSM. It conditions four raw push-buttons and drives the game's guess vector `b` and step enable `en`. It consumes the game's `win`/`lose` outputs to run the press/hold/release handshake and keep saturating win/loss scores. It sits between the board buttons and the game FSM, one instance per game.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a debounced button changes (10 ms at 100 MHz); minimum 1.
- `TICK_DIV`, default 50_000_000: `en` pulse period in clk cycles; minimum 2.
- `SCORE_W`, default 4: width of each score counter.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `btn_raw`  in  4  asynchronous raw buttons, bit i = guess position i.
- `win`  in  1  game in win state.
- `lose`  in  1  game in lose state.
- `b`  out  4  registered guess vector to game.
- `en`  out  1  one-cycle game step pulse.
- `wins`  out  SCORE_W  saturating win count.
- `losses`  out  SCORE_W  saturating loss count.
- `multi_press`  out  1  one-cycle pulse: non-one-hot press rejected (see Configuration).

## Operation
- Per button: 2-flop synchronizer, then debouncer; debounced bit takes sync value after DEBOUNCE_CYCLES consecutive cycles of sync != debounced; any mismatch break restarts count.
- Tick: counter 0..TICK_DIV-1; `en`=1 the cycle counter == TICK_DIV-1, then wraps to 0. Free-running, independent of FSM state.
- Capture FSM (states IDLE, HOLD, SCORE, RELEASE):
  - IDLE: `b`=0. Debounced vector `d` nonzero -> latch `d` into guess reg, `b`=guess, go HOLD.
  - HOLD: `b`=guess regardless of `d` (game samples only on `en`). `win` -> SCORE with win flag; else `lose` -> SCORE with loss flag; `win` has priority if both high.
  - SCORE: one cycle; increment `wins` or `losses` by 1, saturating at all-ones; `b`=guess; go RELEASE.
  - RELEASE: `b`=guess until `d`==0, then `b`=0 and IDLE the same edge. Game returns to start when `b`==0.
- A new press is never accepted before full release, so there is exactly one score per press.
- Reset: all sync/debounce flops 0, tick counter 0, state IDLE, `b`=0, `en`=0, `wins`=0, `losses`=0, `multi_press`=0.

## Timing
- Clean press stable from cycle 0: sync high cycle 2, debounced high cycle 2+DEBOUNCE_CYCLES, `b` high cycle 3+DEBOUNCE_CYCLES.
- Release: `b` drops 3+DEBOUNCE_CYCLES cycles after raw release, given state RELEASE.
- First `en` at cycle TICK_DIV-1 after reset deasserts; then every TICK_DIV cycles.
- Score visible 2 cycles after `win`/`lose` first sampled high in HOLD (HOLD->SCORE, SCORE updates).
- Reset mid-HOLD/RELEASE: `b` 0 next cycle, scores cleared, still-held buttons must re-debounce from 0.
- Bounce shorter than DEBOUNCE_CYCLES never reaches `b`.

## Configuration
- `GUESS_ONEHOT_FILTER_EN` defined: in IDLE, nonzero non-one-hot `d` is not captured; pulse `multi_press` 1 cycle on first such cycle, stay IDLE; capture only when `d` becomes one-hot. One-hot is evaluated on `d` before the capture register. Rejected presses are never scored.
- Undefined: any nonzero `d` captured as-is (game scores it a loss); `multi_press` tied 0.

## Structure
- `guess_pkg`: capture state enum, default DEBOUNCE/TICK constants, one-hot check function.
- Sub-module `button_debounce` (sync + counter, 1 bit, parameter DEBOUNCE_CYCLES), instantiated 4x; tick counter and FSM stay in top.

## Test plan
Bench params: DEBOUNCE_CYCLES=4, TICK_DIV=8, SCORE_W=2.
- Reset, idle 20 cycles -> `en` pulses at cycles 7, 15; `b`=0; scores 0.
- `btn_raw`=0001 held -> `b`=0001 at cycle 7; drive `win`=1 -> `wins`=1 two cycles later; release -> `b`=0 seven cycles after release.
- 3-cycle glitch on `btn_raw[2]` -> `b` stays 0.
- Four win/release rounds -> `wins` saturates at 3; a lose round -> `losses`=1.
- `btn_raw`=0011 with macro -> `multi_press` one pulse, `b`=0; without macro -> `b`=0011.
- Reset asserted in HOLD with button held -> `b`=0 next cycle, recaptured 0001 after DEBOUNCE_CYCLES+3 cycles post-reset.

Source files
------------

// File: rtl/guess_pkg.sv
// guess_pkg -- shared types and constants for the guessing-game player port.
//   capture_state_t        : capture FSM state encoding (also exported for debug)
//   DEFAULT_DEBOUNCE_CYCLES: 10 ms at 100 MHz
//   DEFAULT_TICK_DIV       : en period at 100 MHz (0.5 s)
//   is_onehot()            : true when exactly one bit of a 4-bit vector is set
package guess_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_SCORE   = 2'd2,
    ST_RELEASE = 2'd3
  } capture_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_TICK_DIV        = 50_000_000;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/guess_player_port_if.sv
// guess_player_port_if -- board/game-facing signals of one player port.
//   btn_raw     : raw push-buttons, bit i = guess position i
//   win, lose   : game state inputs
//   b, en       : registered guess vector and one-cycle step pulse to the game
//   wins,losses : saturating score counters (SCORE_W bits)
//   multi_press : one-cycle pulse when a non-one-hot press is rejected
//   state       : capture FSM state, for observation only
// Modports: slave = the player port itself, master = its environment.
// Handshake: there is no valid/ready pair; the player holds b stable from
// capture until full release, and the game may sample b on any cycle en=1.
interface guess_player_port_if #(
  parameter int SCORE_W = 4
);
  import guess_pkg::*;

  logic [3:0]         btn_raw;
  logic               win;
  logic               lose;
  logic [3:0]         b;
  logic               en;
  logic [SCORE_W-1:0] wins;
  logic [SCORE_W-1:0] losses;
  logic               multi_press;
  capture_state_t     state;

  modport slave (
    input  btn_raw, win, lose,
    output b, en, wins, losses, multi_press, state
  );

  modport master (
    output btn_raw, win, lose,
    input  b, en, wins, losses, multi_press, state
  );

endinterface

// File: rtl/button_debounce.sv
// button_debounce -- one-bit 2-flop synchronizer followed by a counting
// debouncer. The debounced output takes the synchronized value only after
// DEBOUNCE_CYCLES consecutive cycles in which the two differ; any cycle of
// agreement restarts the count.
//   clk, reset : clock, synchronous active-high reset
//   raw        : asynchronous button input
//   debounced  : conditioned output
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic debounced
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic          deb_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != deb_q) begin
        // This cycle is the DEBOUNCE_CYCLES-th mismatching one: accept it.
        if (cnt == LAST) begin
          deb_q <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign debounced = deb_q;

endmodule

// File: rtl/guess_player_port.sv
// guess_player_port -- player-side front end for the guessing-game FSM.
// Conditions four raw buttons, captures one guess per press, holds it on b
// until full release, and keeps saturating win/loss scores.
//   clk, reset : clock, synchronous active-high reset
//   bus        : guess_player_port_if.slave (btn_raw, win, lose in;
//                b, en, wins, losses, multi_press, state out)
// Parameters: DEBOUNCE_CYCLES (>=1), TICK_DIV (>=2), SCORE_W.
// Build option: GUESS_ONEHOT_FILTER_EN -- when defined, non-one-hot presses
// are rejected in IDLE with a one-cycle multi_press pulse; otherwise any
// nonzero press is captured and multi_press is tied low.
module guess_player_port
  import guess_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = DEFAULT_TICK_DIV,
  parameter int SCORE_W         = 4
) (
  input  logic clk,
  input  logic reset,
  guess_player_port_if.slave bus
);

  // ---------------- button conditioning ----------------
  logic [3:0] d;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .raw       (bus.btn_raw[i]),
      .debounced (d[i])
    );
  end

  // ---------------- free-running step tick ----------------
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign bus.en = (tick_cnt == TICK_LAST);

  // ---------------- capture FSM ----------------
  capture_state_t     state_q, state_n;
  logic [3:0]         guess_q, guess_n;
  logic [3:0]         b_q, b_n;
  logic               win_flag_q, win_flag_n;
  logic [SCORE_W-1:0] wins_q, wins_n;
  logic [SCORE_W-1:0] losses_q, losses_n;
`ifdef GUESS_ONEHOT_FILTER_EN
  // rejected_q remembers that the current multi-button press was already
  // flagged, so multi_press fires once per press rather than every cycle.
  logic               rejected_q, rejected_n;
  logic               mp_q, mp_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      guess_q    <= 4'd0;
      b_q        <= 4'd0;
      win_flag_q <= 1'b0;
      wins_q     <= '0;
      losses_q   <= '0;
`ifdef GUESS_ONEHOT_FILTER_EN
      rejected_q <= 1'b0;
      mp_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      guess_q    <= guess_n;
      b_q        <= b_n;
      win_flag_q <= win_flag_n;
      wins_q     <= wins_n;
      losses_q   <= losses_n;
`ifdef GUESS_ONEHOT_FILTER_EN
      rejected_q <= rejected_n;
      mp_q       <= mp_n;
`endif
    end
  end

  always_comb begin
    state_n    = state_q;
    guess_n    = guess_q;
    b_n        = b_q;
    win_flag_n = win_flag_q;
    wins_n     = wins_q;
    losses_n   = losses_q;
`ifdef GUESS_ONEHOT_FILTER_EN
    rejected_n = rejected_q;
    mp_n       = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        b_n = 4'd0;
`ifdef GUESS_ONEHOT_FILTER_EN
        if (d == 4'd0) begin
          rejected_n = 1'b0;
        end else if (is_onehot(d)) begin
          rejected_n = 1'b0;
          guess_n    = d;
          b_n        = d;
          state_n    = ST_HOLD;
        end else begin
          rejected_n = 1'b1;
          mp_n       = !rejected_q;
        end
`else
        if (d != 4'd0) begin
          guess_n = d;
          b_n     = d;
          state_n = ST_HOLD;
        end
`endif
      end

      ST_HOLD: begin
        // The game samples b only on en, so button changes here are ignored.
        b_n = guess_q;
        if (bus.win) begin
          win_flag_n = 1'b1;
          state_n    = ST_SCORE;
        end else if (bus.lose) begin
          win_flag_n = 1'b0;
          state_n    = ST_SCORE;
        end
      end

      ST_SCORE: begin
        b_n     = guess_q;
        state_n = ST_RELEASE;
        if (win_flag_q) begin
          if (wins_q != '1) wins_n = wins_q + SCORE_W'(1);
        end else begin
          if (losses_q != '1) losses_n = losses_q + SCORE_W'(1);
        end
      end

      ST_RELEASE: begin
        // Dropping b to 0 is what sends the game back to its start state.
        if (d == 4'd0) begin
          b_n     = 4'd0;
          state_n = ST_IDLE;
        end else begin
          b_n = guess_q;
        end
      end

      default: begin
        b_n     = 4'd0;
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.b      = b_q;
  assign bus.wins   = wins_q;
  assign bus.losses = losses_q;
  assign bus.state  = state_q;
`ifdef GUESS_ONEHOT_FILTER_EN
  assign bus.multi_press = mp_q;
`else
  assign bus.multi_press = 1'b0;
`endif

endmodule

// File: tb/tb_guess_player_port.sv
// tb_guess_player_port -- directed self-checking bench for guess_player_port
// with DEBOUNCE_CYCLES=4, TICK_DIV=8, SCORE_W=2. Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point. "Cycle k"
// means the interval after the k-th rising edge following reset release.
module tb_guess_player_port;
  import guess_pkg::*;

  localparam int DB  = 4;
  localparam int TD  = 8;
  localparam int SW  = 2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  guess_player_port_if #(.SCORE_W(SW)) bus ();

  guess_player_port #(
    .DEBOUNCE_CYCLES (DB),
    .TICK_DIV        (TD),
    .SCORE_W         (SW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking and driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Ends in cycle 0 with btn_raw = btn.
  task automatic do_reset(input logic [3:0] btn);
    reset       = 1'b1;
    bus.btn_raw = 4'd0;
    bus.win     = 1'b0;
    bus.lose    = 1'b0;
    step(2);
    reset       = 1'b0;
    bus.btn_raw = btn;
  endtask

  // Bounded wait for b to reach a value; a timeout shows up as a failed check.
  task automatic wait_b(input string tag, input logic [3:0] exp);
    for (int i = 0; i < 40; i++) begin
      if (bus.b == exp) break;
      step(1);
    end
    check(tag, {28'd0, bus.b}, {28'd0, exp});
  endtask

  // One press/score/release round on a single button.
  task automatic round(input logic [3:0] btn, input logic is_win);
    bus.btn_raw = btn;
    wait_b("round_capture", btn);
    if (is_win) bus.win = 1'b1;
    else        bus.lose = 1'b1;
    step(2);
    bus.win     = 1'b0;
    bus.lose    = 1'b0;
    check("round_state_release", {30'd0, bus.state}, {30'd0, ST_RELEASE});
    bus.btn_raw = 4'd0;
    wait_b("round_release", 4'd0);
    step(1);
  endtask

  // ---------------- stimulus and scoreboard ----------------
  initial begin
    int         mp_cnt;
    logic [3:0] b_or;
    int         exp_mp;
    logic [3:0] exp_b_or;
    int         exp_losses;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.btn_raw = 4'd0;
    bus.win  = 1'b0;
    bus.lose = 1'b0;

    // 1. Reset state and free-running tick.
    do_reset(4'd0);
    check("rst_b",      {28'd0, bus.b}, 32'd0);
    check("rst_wins",   {30'd0, bus.wins}, 32'd0);
    check("rst_losses", {30'd0, bus.losses}, 32'd0);
    check("rst_mp",     {31'd0, bus.multi_press}, 32'd0);
    check("rst_state",  {30'd0, bus.state}, {30'd0, ST_IDLE});
    for (int k = 0; k <= 20; k++) begin
      check($sformatf("en_cyc%0d", k), {31'd0, bus.en}, (k == 7 || k == 15) ? 32'd1 : 32'd0);
      step(1);
    end
    check("idle_b", {28'd0, bus.b}, 32'd0);

    // 2. Clean press from cycle 0: b at cycle 3+DB = 7.
    do_reset(4'b0001);
    step(6);
    check("press_b_cyc6", {28'd0, bus.b}, 32'd0);
    step(1);
    check("press_b_cyc7", {28'd0, bus.b}, 32'h1);
    check("press_state_hold", {30'd0, bus.state}, {30'd0, ST_HOLD});
    bus.win = 1'b1;                 // first sampled at the edge ending cycle 7
    step(1);
    check("win_cyc8", {30'd0, bus.wins}, 32'd0);
    step(1);
    check("win_cyc9", {30'd0, bus.wins}, 32'd1);
    bus.win     = 1'b0;
    bus.btn_raw = 4'd0;             // released in cycle 9 -> b drops cycle 16
    step(6);
    check("rel_b_cyc15", {28'd0, bus.b}, 32'h1);
    step(1);
    check("rel_b_cyc16", {28'd0, bus.b}, 32'd0);
    check("rel_state_idle", {30'd0, bus.state}, {30'd0, ST_IDLE});

    // 3. Three-cycle glitch on button 2 must never reach b.
    b_or = 4'd0;
    bus.btn_raw = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      b_or = b_or | bus.b;
      step(1);
    end
    bus.btn_raw = 4'd0;
    for (int k = 0; k < 15; k++) begin
      b_or = b_or | bus.b;
      step(1);
    end
    check("glitch_b", {28'd0, b_or}, 32'd0);
    check("glitch_state", {30'd0, bus.state}, {30'd0, ST_IDLE});

    // 4. Win saturation at 3, then one loss.
    do_reset(4'd0);
    step(2);
    round(4'b0001, 1'b1);
    check("sat_wins1", {30'd0, bus.wins}, 32'd1);
    round(4'b0010, 1'b1);
    check("sat_wins2", {30'd0, bus.wins}, 32'd2);
    round(4'b0100, 1'b1);
    check("sat_wins3", {30'd0, bus.wins}, 32'd3);
    round(4'b1000, 1'b1);
    check("sat_wins4", {30'd0, bus.wins}, 32'd3);
    round(4'b0010, 1'b0);
    check("lose_losses", {30'd0, bus.losses}, 32'd1);
    check("lose_wins",   {30'd0, bus.wins}, 32'd3);

    // 5. Two buttons at once.
`ifdef GUESS_ONEHOT_FILTER_EN
    exp_mp     = 1;
    exp_b_or   = 4'b0000;
    exp_losses = 1;
`else
    exp_mp     = 0;
    exp_b_or   = 4'b0011;
    exp_losses = 2;
`endif
    mp_cnt = 0;
    b_or   = 4'd0;
    bus.btn_raw = 4'b0011;
    for (int k = 0; k < 14; k++) begin
      step(1);
      mp_cnt += int'(bus.multi_press);
      b_or = b_or | bus.b;
    end
    check("multi_mp_pulses", mp_cnt, exp_mp);
    check("multi_b", {28'd0, b_or}, {28'd0, exp_b_or});
    bus.lose = 1'b1;                // only scored if the press was captured
    step(2);
    bus.lose    = 1'b0;
    bus.btn_raw = 4'd0;
    wait_b("multi_release", 4'd0);
    step(1);
    check("multi_losses", {30'd0, bus.losses}, exp_losses);
    check("multi_state_idle", {30'd0, bus.state}, {30'd0, ST_IDLE});

    // 6. Reset while in HOLD with the button still held.
    bus.btn_raw = 4'b0001;
    wait_b("hold_capture", 4'b0001);
    check("hold_state", {30'd0, bus.state}, {30'd0, ST_HOLD});
    reset = 1'b1;
    step(1);
    check("hold_rst_b",      {28'd0, bus.b}, 32'd0);
    check("hold_rst_wins",   {30'd0, bus.wins}, 32'd0);
    check("hold_rst_losses", {30'd0, bus.losses}, 32'd0);
    reset = 1'b0;                   // cycle 0, button still held
    step(DB + 2);
    check("recap_b_early", {28'd0, bus.b}, 32'd0);
    step(1);
    check("recap_b", {28'd0, bus.b}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
